tt_sweeper: RTL

Parametrised, self-checking exhaustive truth-table sweep engine for combinational lab blocks. On `start` it drives every input combination `0 … 2^N_IN-1` in ascending order, holds each for `HOLD` cycles, and samples the DUT outputs on the last hold cycle. It compares each sample against a packed expected table, counts mismatches, and records the first failing vector. It sits between a clocked harness and any combinational DUT, and replaces hand-written per-vector stimulus blocks.

---
 rtl/tt_sweep_pkg.sv | 40 ++++
 rtl/tt_hold_timer.sv | 29 ++
 rtl/tt_sweeper.sv | 111 +++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for truth-table sweep engines.
// Tables are passed at maximum width so one helper serves every parameterisation.
package tt_sweep_pkg;

    localparam int unsigned MAX_N_IN  = 8;
    localparam int unsigned MAX_N_OUT = 16;
    localparam int unsigned MAX_TBL_W = (2 ** MAX_N_IN) * MAX_N_OUT;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_t;

    // Expected output for vector v; bits at or above n_out are returned as zero.
    function automatic logic [MAX_N_OUT-1:0] exp_slice(
        input logic [MAX_TBL_W-1:0] tbl,
        input int unsigned          v,
        input int unsigned          n_out
    );
        logic [MAX_TBL_W-1:0] sh;
        logic [MAX_N_OUT-1:0] r;
        sh = tbl >> (v * n_out);
        r  = '0;
        for (int unsigned i = 0; i < MAX_N_OUT; i++) begin
            if (i < n_out) r[i] = sh[i];
        end
        return r;
    endfunction

    function automatic bit params_legal(
        input int unsigned n_in,
        input int unsigned n_out,
        input int unsigned hold
    );
        return (n_in >= 1) && (n_in <= MAX_N_IN) &&
               (n_out >= 1) && (n_out <= MAX_N_OUT) && (hold >= 2);
    endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Free-running HOLD-cycle counter; last marks the final cycle of each hold window.
module tt_hold_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic last
);

    localparam int unsigned CW = $clog2(HOLD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(HOLD - 1));

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweep: drives every input vector, samples on the last
// hold cycle, compares against EXPECTED and records error count and first failure.
module tt_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned                N_IN     = 3,
    parameter int unsigned                N_OUT    = 3,
    parameter int unsigned                HOLD     = 10,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int unsigned   VW       = N_IN + 1;
    localparam logic [VW-1:0] LAST_VEC = VW'(2 ** N_IN - 1);

    if (!params_legal(N_IN, N_OUT, HOLD)) begin : g_illegal
        $error("tt_sweeper: illegal N_IN/N_OUT/HOLD combination");
    end

    sweep_state_t     state, state_next;
    logic [VW-1:0]    vec, vec_next;
    logic [VW-1:0]    err_next;
    logic             ffv_next;
    logic [N_IN-1:0]  ffvec_next;
    logic [N_OUT-1:0] exp_now;
    logic             last;

    tt_hold_timer #(
        .HOLD(HOLD)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state != DRIVE),
        .last (last)
    );

    assign exp_now = N_OUT'(exp_slice(MAX_TBL_W'(EXPECTED), 32'(vec), N_OUT));

    always_comb begin
        state_next = state;
        vec_next   = vec;
        err_next   = err_count;
        ffv_next   = first_fail_valid;
        ffvec_next = first_fail_vec;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = DRIVE;
                    vec_next   = '0;
                    err_next   = '0;
                    ffv_next   = 1'b0;
                    ffvec_next = '0;
                end
            end
            DRIVE: begin
                if (last) begin
                    // Case inequality so an X/Z output is scored as a failure.
                    if (dut_out !== exp_now) begin
                        err_next = err_count + 1'b1;
                        if (!first_fail_valid) begin
                            ffv_next   = 1'b1;
                            ffvec_next = vec[N_IN-1:0];
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state_next = DONE;
                    end else begin
                        vec_next = vec + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_next;
            vec              <= vec_next;
            err_count        <= err_next;
            first_fail_valid <= ffv_next;
            first_fail_vec   <= ffvec_next;
            busy             <= (state_next == DRIVE);
            done             <= (state_next == DONE);
            pass             <= (state_next == DONE) && (err_next == '0);
        end
    end

    assign stim = vec[N_IN-1:0];

endmodule
